// File: rtl/emux_tx_mark_pkg.sv
// Shared definitions for the tx mux client chain: the framing state encoding
// and the bit layout of the 10-bit chain word {m, p, d}.
package emux_tx_mark_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_TAIL = 2'd3
    } tx_state_e;

    localparam int OUT_W    = 10;
    localparam int OUT_M    = 9;
    localparam int OUT_P    = 8;
    localparam int OUT_D_HI = 7;
    localparam int OUT_D_LO = 0;

endpackage

// File: rtl/emux_tx_mark.sv
// Upstream feeder of the tx mux chain. Walks the octets of an outgoing UDP
// datagram, marks the second port octet (p) and the payload window (m), and
// reports framing errors plus a completed-frame count.
module emux_tx_mark
    import emux_tx_mark_pkg::*;
#(
    parameter int port_off = 2,
    parameter int len_off  = 4,
    parameter int hdr_len  = 8,
    parameter int jumbo_dw = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_d,
    input  logic                 rx_s,
    output logic [OUT_W-1:0]     out_c,
    output logic [15:0]          pkt_cnt,
    output logic                 err_short,
    output logic                 err_long,
    output logic                 err_len
);

    localparam logic [jumbo_dw-1:0] OC_ONE      = jumbo_dw'(1);
    localparam logic [jumbo_dw-1:0] OC_PORT     = jumbo_dw'(port_off + 1);
    localparam logic [jumbo_dw-1:0] OC_LEN_MSB  = jumbo_dw'(len_off);
    localparam logic [jumbo_dw-1:0] OC_LEN_LSB  = jumbo_dw'(len_off + 1);
    localparam logic [jumbo_dw-1:0] OC_HDR_LAST = jumbo_dw'(hdr_len - 1);
    localparam logic [15:0]         LEN_HDR     = 16'(hdr_len);
    localparam logic [31:0]         LEN_LIMIT   = 32'd1 << jumbo_dw;

    tx_state_e           state_q, state_d;
    logic [jumbo_dw-1:0] oc_q, oc_d;
    logic [15:0]         len_q, len_d;
    logic                long_seen_q, long_seen_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic [15:0]         pkt_q, pkt_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;
    logic                err_len_q, err_len_d;

    logic                m, p;
    logic                len_bad;
    logic                pay_last;
    logic [jumbo_dw-1:0] len_lo;

    // Length decode against the header size and the counter range; the
    // payload ends on the octet whose index is L-1.
    always_comb begin
        len_lo   = len_q[jumbo_dw-1:0];
        len_bad  = (len_q < LEN_HDR) || (32'(len_q) >= LEN_LIMIT);
        pay_last = (oc_q == (len_lo - OC_ONE));
    end

    // Next-state, marks, length latch and error pulses for the current octet.
    always_comb begin
        state_d     = state_q;
        oc_d        = oc_q;
        len_d       = len_q;
        long_seen_d = long_seen_q;
        pkt_d       = pkt_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_len_d   = 1'b0;
        m           = 1'b0;
        p           = 1'b0;
        out_d       = '0;

        if (!rx_s) begin
            // A low strobe closes any open frame; err_len frames already sit
            // in TAIL, so they never also raise err_short.
            state_d     = ST_IDLE;
            oc_d        = '0;
            long_seen_d = 1'b0;
            if (state_q != ST_IDLE) begin
                pkt_d = pkt_q + 16'd1;
                if (state_q == ST_HDR || state_q == ST_PAY) begin
                    err_short_d = 1'b1;
                end
            end
        end else begin
            oc_d = (&oc_q) ? oc_q : (oc_q + OC_ONE);
            p    = (oc_q == OC_PORT);
            if (oc_q == OC_LEN_MSB) len_d[15:8] = rx_d;
            if (oc_q == OC_LEN_LSB) len_d[7:0]  = rx_d;

            case (state_q)
                ST_IDLE: state_d = ST_HDR;
                ST_HDR: begin
                    if (oc_q == OC_HDR_LAST) begin
                        if (len_bad) begin
                            err_len_d = 1'b1;
                            state_d   = ST_TAIL;
                        end else if (len_q == LEN_HDR) begin
                            state_d = ST_TAIL;
                        end else begin
                            state_d = ST_PAY;
                        end
                    end
                end
                ST_PAY: begin
                    m = 1'b1;
                    if (pay_last) state_d = ST_TAIL;
                end
                ST_TAIL: begin
                    if (!long_seen_q) begin
                        err_long_d  = 1'b1;
                        long_seen_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            out_d[OUT_M]             = m;
            out_d[OUT_P]             = p;
            out_d[OUT_D_HI:OUT_D_LO] = rx_d;
        end
    end

    // State, counters and the registered chain word / status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            oc_q        <= '0;
            len_q       <= '0;
            long_seen_q <= 1'b0;
            out_q       <= '0;
            pkt_q       <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            oc_q        <= oc_d;
            len_q       <= len_d;
            long_seen_q <= long_seen_d;
            out_q       <= out_d;
            pkt_q       <= pkt_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_len_q   <= err_len_d;
        end
    end

    assign out_c     = out_q;
    assign pkt_cnt   = pkt_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign err_len   = err_len_q;

endmodule
